// File: rtl/mips_cpu_lsu_if.sv
// Request/response handshake and word-wide data-memory port of the load/store unit.
// The master modport is the LSU itself; slave is the pipeline/memory side.
`timescale 1ns/1ps
interface mips_cpu_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_error;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_readdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_read, mem_write, mem_writedata
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_readdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_read, mem_write, mem_writedata
  );
endinterface

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one request at a time, sub-word stores done as read-modify-write
// on a memory without byte enables, sub-word loads sign/zero-extended.
`timescale 1ns/1ps
module mips_cpu_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_cpu_lsu_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  state_t            state, state_next;
  logic              op_write;
  logic              op_unsigned;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [31:0]       word_q;
  logic [31:0]       result_q;
  logic              error_q;

  logic              req_error;
  logic [ADDR_W-1:0] word_addr;
  logic [4:0]        lane_sh;
  logic [31:0]       lane;
  logic [31:0]       load_ext;
  logic [31:0]       lane_mask;
  logic [31:0]       lane_data;
  logic [31:0]       store_word;

  assign req_error = (bus.req_size == SIZE_BAD)
                   | ((bus.req_size == SIZE_HALF) & bus.req_addr[0])
                   | ((bus.req_size == SIZE_WORD) & (|bus.req_addr[1:0]));

  assign word_addr = {op_addr[ADDR_W-1:2], 2'b00};
  assign lane_sh   = {op_addr[1:0], 3'b000};
  assign lane      = bus.mem_readdata >> lane_sh;

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    load_ext  = lane;
    lane_mask = 32'h0000_0000;
    lane_data = 32'h0000_0000;
    case (op_size)
      SIZE_BYTE: begin
        load_ext  = {{24{lane[7] & ~op_unsigned}}, lane[7:0]};
        lane_mask = 32'h0000_00FF << lane_sh;
        lane_data = {24'h0, op_wdata[7:0]} << lane_sh;
      end
      SIZE_HALF: begin
        load_ext  = {{16{lane[15] & ~op_unsigned}}, lane[15:0]};
        lane_mask = 32'h0000_FFFF << lane_sh;
        lane_data = {16'h0, op_wdata[15:0]} << lane_sh;
      end
      default: ;
    endcase
    store_word = (op_size == SIZE_WORD) ? op_wdata : ((word_q & ~lane_mask) | lane_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state is always updated with non-blocking assignments.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next        = state;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_rdata    = 32'h0;
    bus.resp_error    = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = 32'h0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_error)                                      state_next = RESP;
          else if (bus.req_write && bus.req_size == SIZE_WORD) state_next = WRITE;
          else                                                state_next = READ;
        end
      end
      READ: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = word_addr;
        state_next      = op_write ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_write     = 1'b1;
        bus.mem_address   = word_addr;
        bus.mem_writedata = store_word;
        state_next        = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = result_q;
        bus.resp_error = error_q;
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only at acceptance; the response is built up afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write    <= 1'b0;
      op_unsigned <= 1'b0;
      op_size     <= 2'b00;
      op_addr     <= '0;
      op_wdata    <= 32'h0;
      word_q      <= 32'h0;
      result_q    <= 32'h0;
      error_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          op_write    <= bus.req_write;
          op_unsigned <= bus.req_unsigned;
          op_size     <= bus.req_size;
          op_addr     <= bus.req_addr;
          op_wdata    <= bus.req_wdata;
          result_q    <= 32'h0;
          error_q     <= req_error;
        end
        READ: begin
          if (op_write) word_q   <= bus.mem_readdata;
          else          result_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

endmodule
